// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg -- shared types and constants for the convolution sequencer slice.
//
// Contents:
//   state_t    sequencer FSM states (IDLE, LOAD, CALC, DRAIN, DONE)
//   CH_NUM     channels per pixel / result
//   DATA_W     pixel sample width (signed)
//   RES_W      datapath result width per channel (signed)
//   K_DIM      convolution window side
//   pix_arr_t  one pixel, all channels
//   res_arr_t  one result, all channels
// No ports (package).
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int CH_NUM = 3;
  localparam int DATA_W = 8;
  localparam int RES_W  = 20;
  localparam int K_DIM  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    DRAIN,
    DONE
  } state_t;

  typedef logic signed [DATA_W-1:0] pix_t;
  typedef pix_t [CH_NUM-1:0]        pix_arr_t;

  typedef logic signed [RES_W-1:0]  res_t;
  typedef res_t [CH_NUM-1:0]        res_arr_t;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// conv_seq_ctrl_if -- bundle of the sequencer's data-plane signals.
//
// Signals:
//   in_valid/in_ready/in_data         pixel input stream
//   buf_wr_en/row/col/data            datapath input-buffer write port
//   win_valid/win_row/win_col         window issue to the datapath
//   res_valid/res_data                datapath result return
//   out_valid/out_ready/out_data/idx  result output stream
// Modports:
//   master  the sequencer (conv_seq_ctrl)
//   slave   the environment: pixel source, datapath and result sink
// -----------------------------------------------------------------------------
interface conv_seq_ctrl_if;
  import conv_pkg::*;

  logic       in_valid;
  logic       in_ready;
  pix_arr_t   in_data;

  logic       buf_wr_en;
  logic [2:0] buf_wr_row;
  logic [2:0] buf_wr_col;
  pix_arr_t   buf_wr_data;

  logic       win_valid;
  logic [1:0] win_row;
  logic [1:0] win_col;

  logic       res_valid;
  res_arr_t   res_data;

  logic       out_valid;
  logic       out_ready;
  res_arr_t   out_data;
  logic [3:0] out_idx;

  modport master (
    input  in_valid, in_data, res_valid, res_data, out_ready,
    output in_ready, buf_wr_en, buf_wr_row, buf_wr_col, buf_wr_data,
           win_valid, win_row, win_col, out_valid, out_data, out_idx
  );

  modport slave (
    output in_valid, in_data, res_valid, res_data, out_ready,
    input  in_ready, buf_wr_en, buf_wr_row, buf_wr_col, buf_wr_data,
           win_valid, win_row, win_col, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/conv_res_fifo.sv
// -----------------------------------------------------------------------------
// conv_res_fifo -- synchronous first-word-fall-through result FIFO.
//
// Each entry carries one 3-channel result plus its 4-bit raster index. The
// head entry is visible on head_data/head_idx whenever empty=0 and advances
// on pop. Push and pop in the same cycle are both performed.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset (clears all)
//   push, push_data/idx   write one entry (ignored when full)
//   pop                   remove head entry (ignored when empty)
//   head_data, head_idx   current head entry
//   full, empty, count    occupancy status
// -----------------------------------------------------------------------------
module conv_res_fifo
  import conv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  res_arr_t                    push_data,
  input  logic [3:0]                  push_idx,
  input  logic                        pop,
  output res_arr_t                    head_data,
  output logic [3:0]                  head_idx,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Small depth: kept in registers so the head can be read combinationally
  // (fall-through) and reads back as zero straight after reset.
  res_arr_t      data_mem [FIFO_DEPTH];
  logic [3:0]    idx_mem  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        idx_mem[i]  <= '0;
      end
    end else begin
      if (do_push) begin
        data_mem[wr_ptr_reg] <= push_data;
        idx_mem[wr_ptr_reg]  <= push_idx;
        wr_ptr_reg           <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign head_data = data_mem[rd_ptr_reg];
  assign head_idx  = idx_mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// conv_seq_ctrl -- frame sequencer for a 3x3 convolution datapath.
//
// A frame loads IMG_DIM x IMG_DIM pixels into the datapath input buffer, then
// issues OUT_DIM x OUT_DIM windows in raster order, collects the results in a
// FIFO and streams them out tagged with their raster index.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset (aborts any frame)
//   start          begin a frame (only honoured in IDLE)
//   bus            conv_seq_ctrl_if.master: pixel in, buffer write, window
//                  issue, result return, result out
//   busy           high in every state except IDLE
//   finish         one-cycle pulse in DONE
//   err            sticky: result returned with nothing outstanding, or FIFO full
//   cyc_cnt        busy-cycle counter, present only with CONV_PERF_CNT_EN defined
//
// Optional feature macro: CONV_PERF_CNT_EN (adds cyc_cnt).
// -----------------------------------------------------------------------------
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_DIM    = 6,
  parameter int OUT_DIM    = 4,
  parameter int RES_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  conv_seq_ctrl_if.master bus,
  output logic            busy,
  output logic            finish,
  output logic            err
`ifdef CONV_PERF_CNT_EN
  ,
  output logic [15:0]     cyc_cnt
`endif
);

  // Port widths are fixed for a 6x6 image; reject anything they cannot hold.
  // Result latency is absorbed by the outstanding count, so any RES_LAT >= 1 works.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RES_LAT < 1 ||
      OUT_DIM != IMG_DIM - K_DIM + 1 || OUT_DIM > 4) begin : g_param_check
    $error("conv_seq_ctrl: unsupported parameter set");
  end

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int N_OUT = OUT_DIM * OUT_DIM;

  state_t     state_reg;
  logic       busy_reg;
  logic       finish_reg;
  logic       err_reg;
  logic       in_ready_reg;
  logic [2:0] ld_row_reg;
  logic [2:0] ld_col_reg;
  logic       buf_wr_en_reg;
  logic [2:0] buf_wr_row_reg;
  logic [2:0] buf_wr_col_reg;
  pix_arr_t   buf_wr_data_reg;
  logic       win_valid_reg;
  logic [1:0] win_row_reg;
  logic [1:0] win_col_reg;
  logic [CNT_W-1:0] pend_reg;
  logic [3:0] res_idx_reg;
  logic [4:0] out_cnt_reg;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  res_arr_t         fifo_head_data;
  logic [3:0]       fifo_head_idx;

  logic             beat;
  logic             res_ret;
  logic             push;
  logic             pop;
  logic             res_err;
  logic [CNT_W-1:0] pend_next;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W:0]   outst_next;
  logic             can_issue;
  logic             win_last;
  logic             ld_last;

  assign beat    = bus.in_valid && in_ready_reg;
  // A result with nothing in flight is spurious; one arriving at a full FIFO
  // still retires its window but its data is lost.
  assign res_ret = bus.res_valid && (pend_reg != '0);
  assign push    = res_ret && !fifo_full;
  assign res_err = bus.res_valid && ((pend_reg == '0) || fifo_full);
  assign pop     = !fifo_empty && bus.out_ready;

  // Outstanding work as it will stand after this edge. The window on the bus
  // this cycle already counts, so the next issue decision is exact and
  // back-to-back issue needs no bubble.
  assign pend_next  = pend_reg + CNT_W'(win_valid_reg) - CNT_W'(res_ret);
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign outst_next = (CNT_W+1)'(pend_next) + (CNT_W+1)'(count_next);
  assign can_issue  = outst_next < (CNT_W+1)'(FIFO_DEPTH);

  assign win_last = (win_row_reg == 2'(OUT_DIM - 1)) && (win_col_reg == 2'(OUT_DIM - 1));
  assign ld_last  = (ld_row_reg == 3'(IMG_DIM - 1)) && (ld_col_reg == 3'(IMG_DIM - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      busy_reg        <= 1'b0;
      finish_reg      <= 1'b0;
      err_reg         <= 1'b0;
      in_ready_reg    <= 1'b0;
      ld_row_reg      <= '0;
      ld_col_reg      <= '0;
      buf_wr_en_reg   <= 1'b0;
      buf_wr_row_reg  <= '0;
      buf_wr_col_reg  <= '0;
      buf_wr_data_reg <= '0;
      win_valid_reg   <= 1'b0;
      win_row_reg     <= '0;
      win_col_reg     <= '0;
      pend_reg        <= '0;
      res_idx_reg     <= '0;
      out_cnt_reg     <= '0;
    end else begin
      buf_wr_en_reg <= 1'b0;
      pend_reg      <= pend_next;
      if (res_err) err_reg <= 1'b1;
      if (push)    res_idx_reg <= res_idx_reg + 4'd1;
      if (pop)     out_cnt_reg <= out_cnt_reg + 5'd1;

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= LOAD;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b1;
            ld_row_reg   <= '0;
            ld_col_reg   <= '0;
            win_row_reg  <= '0;
            win_col_reg  <= '0;
            res_idx_reg  <= '0;
            out_cnt_reg  <= '0;
          end
        end

        LOAD: begin
          if (beat) begin
            buf_wr_en_reg   <= 1'b1;
            buf_wr_row_reg  <= ld_row_reg;
            buf_wr_col_reg  <= ld_col_reg;
            buf_wr_data_reg <= bus.in_data;
            if (ld_last) begin
              in_ready_reg  <= 1'b0;
              state_reg     <= CALC;
              win_valid_reg <= can_issue;
            end else if (ld_col_reg == 3'(IMG_DIM - 1)) begin
              ld_col_reg <= '0;
              ld_row_reg <= ld_row_reg + 3'd1;
            end else begin
              ld_col_reg <= ld_col_reg + 3'd1;
            end
          end
        end

        CALC: begin
          // win_row/col always show the next window to issue; they only
          // advance once the window on the bus has gone out.
          if (win_valid_reg && win_last) begin
            win_valid_reg <= 1'b0;
            state_reg     <= DRAIN;
          end else begin
            if (win_valid_reg) begin
              if (win_col_reg == 2'(OUT_DIM - 1)) begin
                win_col_reg <= '0;
                win_row_reg <= win_row_reg + 2'd1;
              end else begin
                win_col_reg <= win_col_reg + 2'd1;
              end
            end
            win_valid_reg <= can_issue;
          end
        end

        DRAIN: begin
          if (pend_reg == '0 && fifo_count == '0 && out_cnt_reg == 5'(N_OUT)) begin
            state_reg  <= DONE;
            finish_reg <= 1'b1;
          end
        end

        DONE: begin
          state_reg  <= IDLE;
          finish_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  conv_res_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.res_data),
    .push_idx  (res_idx_reg),
    .pop       (pop),
    .head_data (fifo_head_data),
    .head_idx  (fifo_head_idx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.in_ready    = in_ready_reg;
  assign bus.buf_wr_en   = buf_wr_en_reg;
  assign bus.buf_wr_row  = buf_wr_row_reg;
  assign bus.buf_wr_col  = buf_wr_col_reg;
  assign bus.buf_wr_data = buf_wr_data_reg;
  assign bus.win_valid   = win_valid_reg;
  assign bus.win_row     = win_row_reg;
  assign bus.win_col     = win_col_reg;
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_data    = fifo_head_data;
  assign bus.out_idx     = fifo_head_idx;

  assign busy   = busy_reg;
  assign finish = finish_reg;
  assign err    = err_reg;

`ifdef CONV_PERF_CNT_EN
  logic [15:0] cyc_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      cyc_cnt_reg <= '0;
    end else if (busy_reg && cyc_cnt_reg != 16'hFFFF) begin
      cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
    end
  end

  assign cyc_cnt = cyc_cnt_reg;
`endif

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IMG_DIM, 6, input image side in pixels.
- OUT_DIM, 4, output side; equals IMG_DIM-2.
- RES_LAT, 1, datapath cycles from win_valid to res_valid.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, at least 2.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic rising-edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, begin a frame; sampled only in IDLE.
- busy, out, 1, high in every state except IDLE.
- finish, out, 1, one-cycle pulse at frame end.
- in_valid / in_ready, in / out, 1 each, input pixel handshake.
- in_data, in, 3x8 signed, one pixel for all 3 channels.
- buf_wr_en, out, 1, datapath input-buffer write strobe.
- buf_wr_row / buf_wr_col, out, 3 each, 0-based write address.
- buf_wr_data, out, 3x8 signed, in_data registered alongside buf_wr_en.
- win_valid, out, 1, issue one 3x3 window to the datapath.
- win_row / win_col, out, 2 each, 0-based window origin.
- res_valid, in, 1, datapath result strobe.
- res_data, in, 3x20 signed, per-channel result.
- out_valid / out_ready, out / in, 1 each, result stream handshake.
- out_data, out, 3x20 signed, result.
- out_idx, out, 4, raster index row*OUT_DIM+col of out_data.
- err, out, 1, sticky protocol error.

Function
REQ-003 FSM states are IDLE, LOAD, CALC, DRAIN and DONE.
REQ-004 IDLE->LOAD on start. A start in any other state is ignored.
REQ-005 In LOAD, in_ready=1; each in_valid&in_ready beat produces buf_wr_en one cycle later, at a raster address (col fastest).
REQ-006 After 36 beats, LOAD->CALC and in_ready drops in the same cycle as the 36th beat is accepted.
REQ-007 In CALC, windows issue in raster order (0,0),(0,1)..(3,3), at most one per cycle.
REQ-008 A window issues only when outstanding < FIFO_DEPTH, where outstanding = issued-not-returned + FIFO occupancy. Otherwise win_valid=0 and the position holds.
REQ-009 Zero-bubble throughput: with out_ready held high, 16 windows issue in 16 consecutive cycles.
REQ-010 CALC->DRAIN in the cycle after window (3,3) issues.
REQ-011 DRAIN->DONE when outstanding=0 and the 16th out beat has been accepted.
REQ-012 DONE->IDLE after one cycle; finish=1 only during DONE.
REQ-013 res_data is written to the FIFO on res_valid. out_idx is an internal 0..15 counter tagged per entry.
REQ-014 out_valid is high whenever the FIFO is non-empty. An entry pops on out_valid&out_ready, and out_data/out_idx hold stable while stalled.
REQ-015 A push and a pop in the same cycle are both performed; occupancy is unchanged.
REQ-016 err sets when res_valid arrives with issued-not-returned=0, or when the FIFO is full. The offending result is dropped and err stays set until reset.
REQ-017 No arithmetic is performed on res_data; the 20-bit width passes through unchanged.

Reset
REQ-018 On reset, the FSM goes to IDLE and all counters and the FIFO clear. busy, finish, in_ready, buf_wr_en, win_valid, out_valid and err are 0; all address and data outputs are 0.
REQ-019 Reset asserted mid-frame aborts the frame on the next edge: no finish pulse, and FIFO contents are discarded.

Configuration
REQ-020 Macro CONV_PERF_CNT_EN.
- Defined: add output cyc_cnt (16 bits), which clears on start, increments every busy cycle, saturates at 16'hFFFF, and holds after DONE until the next start.
- Undefined: cyc_cnt port and logic are absent.

Structure
REQ-021 Shared package conv_pkg holds: the FSM state enum; the constants CH_NUM=3, DATA_W=8, RES_W=20, K_DIM=3; and the pixel and result array typedefs.
REQ-022 The result FIFO is sub-module conv_res_fifo: synchronous, FIFO_DEPTH entries, first-word-fall-through, carrying 3x20 data plus a 4-bit index.

Verification
REQ-023 Nominal frame: start, 36 beats of pixel value k on all channels, out_ready=1, datapath model with RES_LAT=1.
- win_valid high 16 consecutive cycles.
- out_idx 0..15 in order.
- finish exactly once; cyc_cnt=56 when enabled.
REQ-024 Backpressure: out_ready=0 during CALC.
- Exactly 4 windows issue, then win_valid=0 with win_row/col held at (1,0).
- Releasing out_ready resumes issue; all 16 results arrive in order.
REQ-025 Input gaps: in_valid toggles every other cycle.
- 36 buf_wr_en pulses with addresses (0,0)..(5,5).
- No window issues before the last write.
REQ-026 Reset at window 7: assert reset for 1 cycle.
- Next cycle: busy=0, out_valid=0, no finish.
- A new start runs a full clean frame.
REQ-027 Protocol error: inject res_valid in IDLE.
- err=1, FIFO stays empty, err persists until reset.
- start during CALC is ignored: idx sequence unchanged.
